tetromino_gen: RTL and testbench

- Parametrised successor to the fixed block-type-to-shape lookup.
- Draws a pseudo-random tetromino type from an internal LFSR and keeps a one-piece preview.
- Presents the active piece as a GRID×GRID occupancy bitmap and rotates it clockwise on request, iterating one row per cycle.
- Sits between the game-control FSM (requests) and the field/collision logic (consumes shape, block_type, rot_idx).

---
 rtl/tetromino_gen.sv | 172 +++++++++++++++++
 tb/tb_tetromino_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetromino_gen.sv
// Tetromino generator: LFSR-driven piece draw with one-piece preview,
// GRIDxGRID occupancy bitmap of the active piece and a row-serial
// clockwise rotator that only publishes the finished bitmap.
//
//   state | meaning
//   PRIME | first draw after reset, fills the preview only
//   IDLE  | waiting for new_req / rot_req
//   DRAW  | drawing the next preview after a piece was promoted
//   ROT   | building the rotated bitmap one row per cycle
module tetromino_gen #(
  parameter int unsigned       GRID      = 4,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_MASK = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int unsigned       NUM_TYPES = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_req,
  input  logic                   rot_req,
  output logic                   busy,
  output logic                   valid,
  output logic [2:0]             block_type,
  output logic [2:0]             next_type,
  output logic [1:0]             rot_idx,
  output logic [0:GRID*GRID-1]   shape
);

  localparam int unsigned CELLS    = GRID * GRID;
  localparam int unsigned RW       = $clog2(GRID);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID - 1);
  localparam logic [3:0]  TYPES_LIM = 4'(NUM_TYPES);

  localparam logic [1:0] PRIME = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] DRAW  = 2'd2;
  localparam logic [1:0] ROT   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [0:CELLS-1]  shape_q, shape_d;
  logic [0:CELLS-1]  src_q, src_d;
  logic [0:CELLS-1]  work_q, work_d;
  logic [RW-1:0]     row_q, row_d;
  logic [2:0]        block_q, block_d;
  logic [2:0]        next_q, next_d;
  logic [1:0]        rot_q, rot_d;
  logic              valid_q, valid_d;

  logic [15:0]       pat;
  logic [0:CELLS-1]  rom_w;
  logic [0:CELLS-1]  work_step_w;
  logic [0:GRID-1]   rot_row_w [GRID];
  logic [2:0]        draw_val;
  logic              draw_ok;

  // The draw looks at the LFSR value before this edge's update.
  assign draw_val = lfsr_q[2:0];
  assign draw_ok  = ({1'b0, draw_val} < TYPES_LIM);

  // Galois right-shift LFSR step.
  assign lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);

  // 4x4 shape ROM for the preview type, MSB is the top-left cell.
  always_comb begin
    case (next_q)
      3'd0:    pat = 16'h0F00;
      3'd1:    pat = 16'h0660;
      3'd2:    pat = 16'hE400;
      3'd3:    pat = 16'h6C00;
      3'd4:    pat = 16'hC600;
      3'd5:    pat = 16'h8E00;
      3'd6:    pat = 16'h2E00;
      default: pat = 16'h0000;
    endcase
  end

  // Place the 4x4 pattern in the top-left corner of the GRID bitmap and
  // precompute every rotated row plus the work buffer with row_q replaced.
  for (genvar r = 0; r < GRID; r++) begin : g_row
    for (genvar c = 0; c < GRID; c++) begin : g_col
      if (r < 4 && c < 4) begin : g_pat
        assign rom_w[r*GRID + c] = pat[15 - (r*4 + c)];
      end else begin : g_pad
        assign rom_w[r*GRID + c] = 1'b0;
      end
      assign rot_row_w[r][c] = src_q[(GRID - 1 - c)*GRID + r];
    end
    assign work_step_w[r*GRID +: GRID] =
      (row_q == RW'(r)) ? rot_row_w[r] : work_q[r*GRID +: GRID];
  end

  // Control FSM: draw, promote and rotate.
  always_comb begin
    state_d = state_q;
    shape_d = shape_q;
    src_d   = src_q;
    work_d  = work_q;
    row_d   = row_q;
    block_d = block_q;
    next_d  = next_q;
    rot_d   = rot_q;
    valid_d = valid_q;
    case (state_q)
      PRIME, DRAW: begin
        if (draw_ok) begin
          next_d  = draw_val;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (new_req) begin
          block_d = next_q;
          shape_d = rom_w;
          rot_d   = 2'd0;
          valid_d = 1'b1;
          state_d = DRAW;
        end else if (rot_req && valid_q) begin
          src_d   = shape_q;
          work_d  = '0;
          row_d   = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        work_d = work_step_w;
        row_d  = row_q + RW'(1);
        if (row_q == ROW_LAST) begin
          shape_d = work_step_w;
          rot_d   = rot_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: state_d = PRIME;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PRIME;
      lfsr_q  <= SEED;
      shape_q <= '0;
      src_q   <= '0;
      work_q  <= '0;
      row_q   <= '0;
      block_q <= 3'd0;
      next_q  <= 3'd0;
      rot_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      shape_q <= shape_d;
      src_q   <= src_d;
      work_q  <= work_d;
      row_q   <= row_d;
      block_q <= block_d;
      next_q  <= next_d;
      rot_q   <= rot_d;
      valid_q <= valid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign valid      = valid_q;
  assign block_type = block_q;
  assign next_type  = next_q;
  assign rot_idx    = rot_q;
  assign shape      = shape_q;

endmodule

// File: tb/tb_tetromino_gen.sv
// Scoreboard bench for tetromino_gen: expectations are queued when a request
// is issued and popped by a monitor each time the block returns to idle.
module tb_tetromino_gen;

  logic        clk     = 1'b0;
  logic        reset   = 1'b1;
  logic        new_req = 1'b0;
  logic        rot_req = 1'b0;
  logic        busy;
  logic        valid;
  logic [2:0]  block_type;
  logic [2:0]  next_type;
  logic [1:0]  rot_idx;
  logic [0:15] shape;

  tetromino_gen #(.GRID(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_req    (new_req),
    .rot_req    (rot_req),
    .busy       (busy),
    .valid      (valid),
    .block_type (block_type),
    .next_type  (next_type),
    .rot_idx    (rot_idx),
    .shape      (shape)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  bt;
    logic [2:0]  nt;
    logic [1:0]  ri;
    logic [15:0] sh;
    logic        vld;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  m_next;
  logic [2:0]  m_block;
  logic [1:0]  m_rot;
  logic [15:0] m_shape;
  logic        prev_busy = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] rom(input logic [2:0] t);
    case (t)
      3'd0:    return 16'h0F00;
      3'd1:    return 16'h0660;
      3'd2:    return 16'hE400;
      3'd3:    return 16'h6C00;
      3'd4:    return 16'hC600;
      3'd5:    return 16'h8E00;
      3'd6:    return 16'h2E00;
      default: return 16'h0000;
    endcase
  endfunction

  // Draw outcome starting from the LFSR value seen at the first draw edge.
  task automatic predict(input logic [15:0] start, output logic [2:0] t, output int cyc);
    logic [15:0] v;
    v   = start;
    cyc = 1;
    while (v[2:0] == 3'd7 && cyc < 100) begin
      v = lstep(v);
      cyc++;
    end
    t = v[2:0];
  endtask

  // Reference LFSR running alongside the design.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lstep(m_lfsr);
  end

  // Monitor: every busy->idle transition is one completed response.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b1;
    end else begin
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_response: got idle with empty queue at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_block_type", 32'(block_type), 32'(mon_e.bt));
          check("sb_next_type",  32'(next_type),  32'(mon_e.nt));
          check("sb_rot_idx",    32'(rot_idx),    32'(mon_e.ri));
          check("sb_shape",      32'(shape),      32'(mon_e.sh));
          check("sb_valid",      32'(valid),      32'(mon_e.vld));
        end
      end
      prev_busy = busy;
    end
  end

  // Promote the preview; optionally raise rot_req with it, or poke rot_req
  // during the draw cycle.
  task automatic do_new(input logic with_rot, input logic poke);
    logic [2:0] t;
    int         cyc;
    int         n;
    exp_t       e;
    predict(lstep(m_lfsr), t, cyc);
    e.bt = m_next; e.nt = t; e.ri = 2'd0; e.sh = rom(m_next); e.vld = 1'b1;
    sb_q.push_back(e);
    new_req = 1'b1;
    rot_req = with_rot;
    @(negedge clk);
    new_req = 1'b0;
    rot_req = 1'b0;
    check("new_block_type", 32'(block_type), 32'(m_next));
    check("new_shape",      32'(shape),      32'(rom(m_next)));
    check("new_valid",      32'(valid),      32'd1);
    check("new_rot_idx",    32'(rot_idx),    32'd0);
    m_block = m_next;
    m_shape = rom(m_next);
    m_rot   = 2'd0;
    m_next  = t;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) break;
      n++;
      rot_req = poke && (i == 0);
      @(negedge clk);
    end
    rot_req = 1'b0;
    check("draw_busy_cycles", 32'(n), 32'(cyc));
  endtask

  // Rotate the active piece; shape must hold until the final edge.
  task automatic do_rot(input logic [15:0] hand_exp, input logic poke);
    int   n;
    exp_t e;
    e.bt = m_block; e.nt = m_next; e.ri = m_rot + 2'd1; e.sh = hand_exp; e.vld = 1'b1;
    sb_q.push_back(e);
    rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n++;
      check("rot_shape_hold", 32'(shape), 32'(m_shape));
      rot_req = poke && (i == 1);
      new_req = poke && (i == 1);
      @(negedge clk);
    end
    rot_req = 1'b0;
    new_req = 1'b0;
    check("rot_busy_cycles", 32'(n), 32'd4);
    m_shape = hand_exp;
    m_rot   = m_rot + 2'd1;
  endtask

  // Draw pieces until the preview is the target type, then promote it.
  task automatic load_type(input logic [2:0] target);
    int k;
    for (k = 0; k < 60; k++) begin
      if (m_next == target) break;
      do_new(1'b0, 1'b0);
    end
    if (m_next != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_type: preview %0d never reached %0d", m_next, target);
    end
    do_new(1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] t;
    int         cyc;
    exp_t       e;

    m_block = 3'd0; m_rot = 2'd0; m_shape = 16'h0;
    predict(16'hACE1, t, cyc);

    repeat (2) @(negedge clk);
    check("rst_shape",      32'(shape),      32'h0);
    check("rst_block_type", 32'(block_type), 32'd0);
    check("rst_next_type",  32'(next_type),  32'd0);
    check("rst_rot_idx",    32'(rot_idx),    32'd0);
    check("rst_valid",      32'(valid),      32'd0);
    check("rst_busy",       32'(busy),       32'd1);

    e.bt = 3'd0; e.nt = t; e.ri = 2'd0; e.sh = 16'h0; e.vld = 1'b0;
    sb_q.push_back(e);
    m_next = t;
    reset = 1'b0;
    @(negedge clk);
    check("prime_next_type", 32'(next_type), 32'd1);
    check("prime_busy",      32'(busy),      32'd0);
    check("prime_valid",     32'(valid),     32'd0);

    // First piece is the O from the seed; rot_req poked during the draw.
    do_new(1'b0, 1'b1);
    check("first_block_type", 32'(block_type), 32'd1);
    check("first_shape",      32'(shape),      32'h0660);
    check("draw_rot_ignored", 32'(rot_idx),    32'd0);

    // O is rotation-invariant; requests during ROT are dropped.
    do_rot(16'h0660, 1'b1);

    // T through a full turn and one step further.
    load_type(3'd2);
    do_rot(16'h1310, 1'b0);
    do_rot(16'h0027, 1'b0);
    do_rot(16'h08C8, 1'b0);
    do_rot(16'hE400, 1'b0);
    check("t_wrap_rot_idx", 32'(rot_idx), 32'd0);
    do_rot(16'h1310, 1'b0);
    check("t_rot_idx_1", 32'(rot_idx), 32'd1);

    // new_req and rot_req together: the new piece wins.
    do_new(1'b1, 1'b0);

    // I piece.
    load_type(3'd0);
    do_rot(16'h2222, 1'b0);
    do_rot(16'h00F0, 1'b0);

    // Reset in the middle of a rotation.
    rot_req = 1'b1;
    @(negedge clk);
    rot_req = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_shape",   32'(shape),   32'h0);
    check("abort_valid",   32'(valid),   32'd0);
    check("abort_rot_idx", 32'(rot_idx), 32'd0);
    check("abort_busy",    32'(busy),    32'd1);
    @(negedge clk);
    @(negedge clk);
    m_block = 3'd0; m_rot = 2'd0; m_shape = 16'h0;
    predict(16'hACE1, t, cyc);
    e.bt = 3'd0; e.nt = t; e.ri = 2'd0; e.sh = 16'h0; e.vld = 1'b0;
    sb_q.push_back(e);
    m_next = t;
    reset = 1'b0;
    @(negedge clk);
    check("reprime_next_type", 32'(next_type), 32'd1);
    check("reprime_busy",      32'(busy),      32'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
